matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter ARRAY_W_W, default 2, rows of weight matrix W.
REQ-003 SHALL have parameter ARRAY_W_L, default 5, columns of W.
REQ-004 SHALL have parameter ARRAY_A_W, default 5, rows of data matrix B.
REQ-005 SHALL have parameter ARRAY_A_L, default 2, columns of B.
REQ-006 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-007 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  incoming matrix element.
REQ-009 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-010 SHALL have port in_ready  output  1  loader accepts an element this cycle.
REQ-011 SHALL have port flush  input  1  abort current load; restart at W[0][0].
REQ-012 SHALL have port comp_ready  input  1  fetcher "multiplication finished" level.
REQ-013 SHALL have port data_w  output  packed [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]  assembled W.
REQ-014 SHALL have port data_b  output  packed [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]  assembled B.
REQ-015 SHALL have port load_params  output  1  one-cycle pulse to fetcher to load data_w/data_b.
REQ-016 SHALL have port start_comp  output  1  one-cycle pulse to fetcher to start computation.
REQ-017 SHALL have port done  output  1  one-cycle pulse when computation completes.
REQ-018 SHALL have port state  output  3  current FSM state code, for LEDs.

Function
REQ-019 SHALL implement FSM: LOAD_W=0, LOAD_B=1, LOAD=2, START=3, WAIT=4.
REQ-020 SHALL drive in_ready=1 only in LOAD_W and LOAD_B; 0 otherwise.
REQ-021 SHALL accept an element on a cycle with in_valid=1 and in_ready=1 and flush=0; write it at that clock edge to the matrix position given by the row/col counters.
REQ-022 SHALL fill elements row-major (col increments; on col=last, col=0 and row increments).
REQ-023 SHALL move LOAD_W->LOAD_B on acceptance of W[ARRAY_W_W-1][ARRAY_W_L-1], with row/col reset to 0.
REQ-024 SHALL move LOAD_B->LOAD on acceptance of B[ARRAY_A_W-1][ARRAY_A_L-1].
REQ-025 SHALL assert load_params for exactly the one cycle spent in LOAD, then go to START.
REQ-026 SHALL assert start_comp for exactly the one cycle spent in START, then go to WAIT.
REQ-027 SHALL, in WAIT, register comp_ready and leave on its rising edge (comp_ready=1, previous sample=0); a level already high on WAIT entry SHALL NOT count.
REQ-028 SHALL pulse done for one cycle coincident with the WAIT->LOAD_W transition; row/col return to 0.
REQ-029 SHALL hold data_w/data_b stable from LOAD through WAIT; contents persist until overwritten by the next load (no clearing between runs).
REQ-030 SHALL, on flush=1 in any state, go to LOAD_W with row/col=0 next cycle, discard any element presented that cycle, not assert load_params/start_comp/done that cycle, and keep matrix contents.
REQ-031 SHALL ignore in_valid outside LOAD_W/LOAD_B (no write, no counter change).
REQ-032 SHALL keep the in_valid-to-load_params latency at one cycle after the last B element acceptance.

Reset
REQ-033 SHALL, while reset_n=0 at a posedge, set state=LOAD_W, row=col=0, data_w=data_b=0, load_params=start_comp=done=0, comp_ready sample=0; in_ready=1 from the first cycle after reset release.
REQ-034 SHALL give reset_n priority over flush and in_valid; reset mid-WAIT SHALL abandon the computation with no done pulse.

Verification
REQ-035 Stream 1..10 into W then 11..20 into B with in_valid held -> data_w[0][0]=1, data_w[1][4]=10, data_b[0][0]=11, data_b[4][1]=20; load_params high 1 cycle after last accept, start_comp the next cycle.
REQ-036 Gap in_valid (accept every 3rd cycle) -> same final matrices; counters advance only on accepted cycles.
REQ-037 comp_ready held 1 entering WAIT, drops 2 cycles, rises -> done exactly one cycle after rise sampled; never before.
REQ-038 flush after 7 W elements, then stream 10 new W + 10 B -> W starts at [0][0]; exactly one load_params/start_comp.
REQ-039 in_valid=1 during LOAD/START/WAIT with value 0xFF -> no matrix change, in_ready=0.
REQ-040 reset_n=0 for 1 cycle during WAIT -> all outputs 0, state=LOAD_W, matrices zeroed, no done pulse.

Source files
------------

// File: rtl/matrix_loader.sv
// Streams W then B elements row-major into packed matrices, then sequences the
// fetcher handshake: load_params, start_comp, wait for comp_ready rise, done.
module matrix_loader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ARRAY_W_W  = 2,
    parameter int unsigned ARRAY_W_L  = 5,
    parameter int unsigned ARRAY_A_W  = 5,
    parameter int unsigned ARRAY_A_L  = 2
) (
    input  logic                                                   clk,
    input  logic                                                   reset_n,
    input  logic [DATA_WIDTH-1:0]                                  in_data,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic                                                   flush,
    input  logic                                                   comp_ready,
    output logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]    data_w,
    output logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]    data_b,
    output logic                                                   load_params,
    output logic                                                   start_comp,
    output logic                                                   done,
    output logic [2:0]                                             state
);

    typedef enum logic [2:0] {
        StLoadW = 3'd0,
        StLoadB = 3'd1,
        StLoad  = 3'd2,
        StStart = 3'd3,
        StWait  = 3'd4
    } state_e;

    localparam int unsigned MaxRows = (ARRAY_W_W > ARRAY_A_W) ? ARRAY_W_W : ARRAY_A_W;
    localparam int unsigned MaxCols = (ARRAY_W_L > ARRAY_A_L) ? ARRAY_W_L : ARRAY_A_L;
    localparam int unsigned MaxDim  = (MaxRows > MaxCols) ? MaxRows : MaxCols;
    localparam int unsigned CntW    = (MaxDim > 1) ? $clog2(MaxDim) : 1;

    localparam logic [CntW-1:0] LastWRow = CntW'(ARRAY_W_W - 1);
    localparam logic [CntW-1:0] LastWCol = CntW'(ARRAY_W_L - 1);
    localparam logic [CntW-1:0] LastBRow = CntW'(ARRAY_A_W - 1);
    localparam logic [CntW-1:0] LastBCol = CntW'(ARRAY_A_L - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] row_q, row_d;
    logic [CntW-1:0] col_q, col_d;
    logic            comp_q;
    logic            load_params_q, load_params_d;
    logic            start_comp_q, start_comp_d;
    logic            done_q, done_d;
    logic            wr_w, wr_b;

    logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] data_w_q;
    logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] data_b_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StLoadW;
            row_q         <= '0;
            col_q         <= '0;
            comp_q        <= 1'b0;
            load_params_q <= 1'b0;
            start_comp_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            comp_q        <= comp_ready;
            load_params_q <= load_params_d;
            start_comp_q  <= start_comp_d;
            done_q        <= done_d;
        end
    end

    // Pulse outputs are registered off the transition into their state so each
    // is high for exactly the cycle spent in that state.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        load_params_d = 1'b0;
        start_comp_d  = 1'b0;
        done_d        = 1'b0;
        wr_w          = 1'b0;
        wr_b          = 1'b0;

        if (flush) begin
            state_d = StLoadW;
            row_d   = '0;
            col_d   = '0;
        end else begin
            unique case (state_q)
                StLoadW: begin
                    if (in_valid) begin
                        wr_w = 1'b1;
                        if (col_q == LastWCol) begin
                            col_d = '0;
                            if (row_q == LastWRow) begin
                                row_d   = '0;
                                state_d = StLoadB;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                StLoadB: begin
                    if (in_valid) begin
                        wr_b = 1'b1;
                        if (col_q == LastBCol) begin
                            col_d = '0;
                            if (row_q == LastBRow) begin
                                row_d         = '0;
                                state_d       = StLoad;
                                load_params_d = 1'b1;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                StLoad: begin
                    state_d      = StStart;
                    start_comp_d = 1'b1;
                end
                StStart: begin
                    state_d = StWait;
                end
                StWait: begin
                    // Only a fresh rise counts; a level already high on entry is ignored.
                    if (comp_ready && !comp_q) begin
                        state_d = StLoadW;
                        done_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                default: begin
                    state_d = StLoadW;
                    row_d   = '0;
                    col_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_w_q <= '0;
        end else begin
            for (int unsigned r = 0; r < ARRAY_W_W; r++) begin
                for (int unsigned c = 0; c < ARRAY_W_L; c++) begin
                    if (wr_w && row_q == CntW'(r) && col_q == CntW'(c)) begin
                        data_w_q[r][c] <= in_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_b_q <= '0;
        end else begin
            for (int unsigned r = 0; r < ARRAY_A_W; r++) begin
                for (int unsigned c = 0; c < ARRAY_A_L; c++) begin
                    if (wr_b && row_q == CntW'(r) && col_q == CntW'(c)) begin
                        data_b_q[r][c] <= in_data;
                    end
                end
            end
        end
    end

    assign in_ready    = (state_q == StLoadW) || (state_q == StLoadB);
    assign data_w      = data_w_q;
    assign data_b      = data_b_q;
    assign load_params = load_params_q;
    assign start_comp  = start_comp_q;
    assign done        = done_q;
    assign state       = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: expected matrices are queued as each load is
// driven and compared whenever the loader pulses load_params.
module tb_matrix_loader;

    typedef logic [0:1][0:4][7:0] mat_w_t;
    typedef logic [0:4][0:1][7:0] mat_b_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       comp_ready;
    mat_w_t     data_w;
    mat_b_t     data_b;
    logic       load_params;
    logic       start_comp;
    logic       done;
    logic [2:0] state;

    int n_cmp = 0;
    int n_mis = 0;
    int n_lp  = 0;
    logic prev_lp = 1'b0;

    mat_w_t exp_w_q[$];
    mat_b_t exp_b_q[$];
    mat_w_t cur_w;
    mat_b_t cur_b;

    matrix_loader #(
        .DATA_WIDTH (8),
        .ARRAY_W_W  (2),
        .ARRAY_W_L  (5),
        .ARRAY_A_W  (5),
        .ARRAY_A_L  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .comp_ready  (comp_ready),
        .data_w      (data_w),
        .data_b      (data_b),
        .load_params (load_params),
        .start_comp  (start_comp),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every load_params pulse must match the oldest queued load.
    always @(negedge clk) begin
        if (load_params) begin
            n_lp++;
            if (exp_w_q.size() == 0) begin
                check("lp_unexpected", 1, 0);
            end else begin
                check("lp_data_w", data_w, exp_w_q.pop_front());
                check("lp_data_b", data_b, exp_b_q.pop_front());
            end
        end
        if (start_comp) check("sc_after_lp", prev_lp, 1);
        prev_lp = load_params;
    end

    task automatic send(input logic [7:0] v, input int gap);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        if (gap > 0) begin
            in_valid = 1'b0;
            in_data  = 8'hAA;
            repeat (gap) tick();
        end
    endtask

    // Streams a full W then B load and runs through LOAD/START into WAIT.
    task automatic load_run(input int w0, input int b0, input int gap);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 5; c++) cur_w[r][c] = 8'(w0 + r * 5 + c);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 2; c++) cur_b[r][c] = 8'(b0 + r * 2 + c);
        exp_w_q.push_back(cur_w);
        exp_b_q.push_back(cur_b);
        for (int i = 0; i < 10; i++) send(8'(w0 + i), gap);
        for (int i = 0; i < 10; i++) send(8'(b0 + i), (i == 9) ? 0 : gap);
        in_data = 8'hFF;
        @(negedge clk);
        check("lp_latency", load_params, 1);
        check("state_load", state, 3'd2);
        check("rdy_load", in_ready, 0);
        tick();
        @(negedge clk);
        check("sc_pulse", start_comp, 1);
        check("lp_single", load_params, 0);
        check("state_start", state, 3'd3);
        check("rdy_start", in_ready, 0);
        tick();
        @(negedge clk);
        check("state_wait", state, 3'd4);
        check("sc_single", start_comp, 0);
    endtask

    task automatic finish_run();
        repeat (2) begin
            @(negedge clk);
            check("wait_hold_done", done, 0);
            check("rdy_wait", in_ready, 0);
            tick();
        end
        in_valid   = 1'b0;
        comp_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("wait_low_done", done, 0);
            check("wait_low_state", state, 3'd4);
            tick();
        end
        check("w_unchanged", data_w, cur_w);
        check("b_unchanged", data_b, cur_b);
        comp_ready = 1'b1;
        @(negedge clk);
        check("done_early", done, 0);
        tick();
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_state", state, 3'd0);
        check("done_rdy", in_ready, 1);
        tick();
        @(negedge clk);
        check("done_single", done, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        flush      = 1'b0;
        comp_ready = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_rdy", in_ready, 1);
        check("rst_w", data_w, 0);
        check("rst_b", data_b, 0);
        check("rst_pulses", {load_params, start_comp, done}, 3'b000);
        tick();

        // Back-to-back stream, in_valid=0xFF held through LOAD/START/WAIT.
        load_run(1, 11, 0);
        check("w00", data_w[0][0], 8'd1);
        check("w14", data_w[1][4], 8'd10);
        check("b00", data_b[0][0], 8'd11);
        check("b41", data_b[4][1], 8'd20);
        finish_run();

        // Gapped stream, comp_ready still high from the previous run.
        load_run(101, 121, 2);
        finish_run();

        // Flush after seven W elements, with a discarded element on the flush cycle.
        for (int i = 0; i < 7; i++) send(8'(200 + i), 0);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_no_lp", load_params, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_state", state, 3'd0);
        check("flush_keep_w00", data_w[0][0], 8'd200);
        check("flush_keep_w11", data_w[1][1], 8'd206);
        check("flush_discard_w12", data_w[1][2], cur_w[1][2]);
        tick();
        load_run(50, 60, 0);
        check("flush_w00", data_w[0][0], 8'd50);
        finish_run();

        // Reset for one cycle mid-WAIT while comp_ready rises.
        load_run(70, 80, 0);
        in_valid   = 1'b0;
        comp_ready = 1'b0;
        tick();
        reset_n    = 1'b0;
        comp_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("wrst_state", state, 3'd0);
        check("wrst_w", data_w, 0);
        check("wrst_b", data_b, 0);
        check("wrst_pulses", {load_params, start_comp, done}, 3'b000);
        check("wrst_rdy", in_ready, 1);
        repeat (4) begin
            tick();
            @(negedge clk);
            check("wrst_no_done", done, 0);
        end

        check("lp_count", n_lp, 4);
        check("queue_empty", exp_w_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
